add_pipe_core: RTL and testbench
================================

ADD_PIPE_CORE -- requirements
Module: add_pipe_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: operand/result width, legal 1..64.
REQ-002 SHALL have parameter STAGES, default 2: pipeline depth in registers, legal 1..8.
REQ-003 SHALL have parameter SAT_MODE, default 0: 0 = wrap result, 1 = unsigned saturate on carry-out.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1: operand set offered.
REQ-007 SHALL have port in_ready, output, 1: block accepts operands this cycle.
REQ-008 SHALL have port in_a, input, DATA_WIDTH: operand A, unsigned.
REQ-009 SHALL have port in_b, input, DATA_WIDTH: operand B, unsigned.
REQ-010 SHALL have port in_cin, input, 1: carry-in.
REQ-011 SHALL have port out_valid, output, 1: result available.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-013 SHALL have port out_sum, output, DATA_WIDTH: result.
REQ-014 SHALL have port out_ovf, output, 1: carry-out of the unsaturated sum.
REQ-015 SHALL have port ovf_count, output, 16: overflow counter (present only under ADD_PIPE_OVF_CNT_EN).

Function
REQ-016 Input handshake SHALL occur when in_valid && in_ready at a rising clk edge; output handshake when out_valid && out_ready.
REQ-017 Raw sum SHALL be in_a + in_b + in_cin, computed at DATA_WIDTH+1 bits; out_ovf = bit DATA_WIDTH.
REQ-018 SAT_MODE=0: out_sum = raw sum low DATA_WIDTH bits. SAT_MODE=1: out_sum = all-ones when out_ovf=1, else low bits.
REQ-019 Pipeline SHALL hold STAGES register stages, each with its own valid bit; the result exits the last stage.
REQ-020 Stage k SHALL load when it is empty or stage k+1 loads in the same cycle; the last stage loads when empty or an output handshake occurs.
REQ-021 in_ready SHALL equal the stage-1 load condition, combinationally; in_ready SHALL NOT depend on in_valid.
REQ-022 With out_ready held high, latency SHALL be exactly STAGES cycles from input handshake to out_valid=1, with throughput 1 result/cycle.
REQ-023 While out_valid && !out_ready, out_sum and out_ovf SHALL hold stable; bubbles upstream SHALL still collapse, so up to STAGES results are buffered.
REQ-024 Full condition: all stages valid and out_ready=0 -> in_ready=0; no operand SHALL be lost or duplicated.
REQ-025 Simultaneous output handshake and input handshake on a full pipe SHALL be allowed: one result leaves and one operand set enters in the same cycle.
REQ-026 Results SHALL leave in acceptance order.

Reset
REQ-027 rst_n low SHALL asynchronously clear all stage valid bits, out_valid=0, out_sum=0, out_ovf=0, ovf_count=0.
REQ-028 in_ready SHALL be 1 during reset.
REQ-029 Reset mid-operation SHALL discard all in-flight results; no result SHALL appear after deassertion until a new input handshake.

Configuration
REQ-030 Macro ADD_PIPE_OVF_CNT_EN defined: ovf_count SHALL increment by 1 on each output handshake with out_ovf=1, saturating at 16'hFFFF.
REQ-031 Macro ADD_PIPE_OVF_CNT_EN undefined: port ovf_count and the counter SHALL be absent; all other behaviour SHALL be identical.

Verification (DATA_WIDTH=8, STAGES=2 unless noted)
REQ-032 Single op a=8'h12, b=8'h34, cin=0, out_ready=1 -> out_valid exactly 2 cycles later, out_sum=8'h46, out_ovf=0.
REQ-033 Overflow a=8'hF0, b=8'h20, cin=1: SAT_MODE=0 -> out_sum=8'h11, out_ovf=1; SAT_MODE=1 -> out_sum=8'hFF, out_ovf=1.
REQ-034 Back-to-back 10 ops, out_ready=1 -> 10 results on 10 consecutive cycles, in order, in_ready constantly 1.
REQ-035 out_ready=0 and 3 offered ops -> 2 accepted, in_ready=0 on the third, first result held stable; out_ready=1 -> 3 results in order, none lost.
REQ-036 rst_n pulsed low with 2 ops in flight -> out_valid=0 immediately, no stale result after release; with ADD_PIPE_OVF_CNT_EN, ovf_count=0.
REQ-037 With ADD_PIPE_OVF_CNT_EN, 5 overflowing ops drained -> ovf_count=5; counter preset near 16'hFFFF holds at 16'hFFFF.

Source files
------------

// File: rtl/add_pipe_core.sv
// rtl/add_pipe_core.sv - elastic pipelined adder with optional wrap/saturate result
// Optional overflow counter port ovf_count is built when ADD_PIPE_OVF_CNT_EN is defined.
module add_pipe_core #(
  parameter int DATA_WIDTH = 8,
  parameter int STAGES     = 2,
  parameter int SAT_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
`ifdef ADD_PIPE_OVF_CNT_EN
  output logic                  out_ovf,
  output logic [15:0]           ovf_count
`else
  output logic                  out_ovf
`endif
);

  logic [DATA_WIDTH:0]   raw_sum;
  logic [DATA_WIDTH-1:0] res_sum;
  logic [STAGES-1:0]     vld;
  logic [STAGES-1:0]     load;
  logic [STAGES-1:0]     ovf_q;
  logic [DATA_WIDTH-1:0] sum_q [STAGES];

  assign raw_sum = {1'b0, in_a} + {1'b0, in_b} + {{DATA_WIDTH{1'b0}}, in_cin};

  always_comb begin
    res_sum = raw_sum[DATA_WIDTH-1:0];
    if ((SAT_MODE != 0) && raw_sum[DATA_WIDTH]) begin
      res_sum = '1;
    end
  end

  // A stage may load if any stage at or after it has a hole, or the output drains;
  // written without chaining so bubbles collapse in a single cycle.
  for (genvar k = 0; k < STAGES; k++) begin : g_load
    assign load[k] = out_ready || !(&vld[STAGES-1:k]);
  end

  assign in_ready = load[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= '0;
      ovf_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
      end
    end else begin
      if (load[0]) begin
        vld[0] <= in_valid;
        if (in_valid) begin
          sum_q[0] <= res_sum;
          ovf_q[0] <= raw_sum[DATA_WIDTH];
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) begin
          vld[k] <= vld[k-1];
          if (vld[k-1]) begin
            sum_q[k] <= sum_q[k-1];
            ovf_q[k] <= ovf_q[k-1];
          end
        end
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign out_sum   = sum_q[STAGES-1];
  assign out_ovf   = ovf_q[STAGES-1];

`ifdef ADD_PIPE_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (out_valid && out_ready && out_ovf && (ovf_count != 16'hFFFF)) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_add_pipe_core.sv
// tb/tb_add_pipe_core.sv - scoreboard bench for add_pipe_core (wrap and saturating instances)
module tb_add_pipe_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_cin;
  logic [7:0] in_a, in_b;
  logic       out_valid, out_ready, out_ovf;
  logic [7:0] out_sum;
  logic       s_ready, s_out_valid, s_ovf;
  logic [7:0] s_sum;
  logic       s_out_ready;
`ifdef ADD_PIPE_OVF_CNT_EN
  logic [15:0] ovf_count, s_ovf_count;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_pop    = 0;
  logic [8:0] exp_q [$];
  logic [8:0] sat_q [$];
  int         out_cyc [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  add_pipe_core #(.DATA_WIDTH(8), .STAGES(2), .SAT_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum),
`ifdef ADD_PIPE_OVF_CNT_EN
    .out_ovf(out_ovf), .ovf_count(ovf_count)
`else
    .out_ovf(out_ovf)
`endif
  );

  add_pipe_core #(.DATA_WIDTH(8), .STAGES(3), .SAT_MODE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_sum(s_sum),
`ifdef ADD_PIPE_OVF_CNT_EN
    .out_ovf(s_ovf), .ovf_count(s_ovf_count)
`else
    .out_ovf(s_ovf)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic c, input bit sat);
    logic [8:0] raw;
    raw = {1'b0, a} + {1'b0, b} + {8'd0, c};
    if (sat && raw[8]) return {1'b1, 8'hFF};
    return raw;
  endfunction

  // Pop on output handshake, push on input handshake; both fire at the next posedge.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("main_extra", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_eq("main_sum", out_sum, e[7:0]);
          check_eq("main_ovf", out_ovf, e[8]);
        end
        out_cyc.push_back(cyc);
        n_pop++;
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, 1'b0));
      if (s_out_valid && s_out_ready) begin
        if (sat_q.size() == 0) check_eq("sat_extra", 1, 0);
        else begin
          e = sat_q.pop_front();
          check_eq("sat_sum", s_sum, e[7:0]);
          check_eq("sat_ovf", s_ovf, e[8]);
        end
      end
      if (in_valid && s_ready) sat_q.push_back(model(in_a, in_b, in_cin, 1'b1));
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c, output int waits);
    bit ok;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = c;
    ok = 1'b0;
    waits = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    if (!ok) check_eq("send_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int  w, n0;
    bit  seen;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    out_ready = 1'b1; s_out_ready = 1'b1;
    #2;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_sum", out_sum, 0);
    check_eq("rst_out_ovf", out_ovf, 0);
    check_eq("rst_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // single op latency
    send(8'h12, 8'h34, 1'b0, w);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("lat_cycle1_valid", out_valid, 0);
    @(negedge clk);
    check_eq("lat_cycle2_valid", out_valid, 1);
    check_eq("lat_sum", out_sum, 8'h46);
    drain(4);

    // overflow: wrap on main, saturate on dut_sat
    send(8'hF0, 8'h20, 1'b1, w);
    drain(5);

    // back-to-back stream
    out_cyc.delete();
    for (int i = 0; i < 10; i++) begin
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), w);
      check_eq("b2b_in_ready", w, 0);
    end
    drain(5);
    check_eq("b2b_count", out_cyc.size(), 10);
    if (out_cyc.size() == 10) check_eq("b2b_consecutive", out_cyc[9] - out_cyc[0], 9);

    // backpressure: two fill the pipe, third waits, first result held
    out_ready = 1'b0;
    n0 = n_pop;
    send(8'h01, 8'h02, 1'b0, w);
    send(8'h10, 8'h20, 1'b0, w);
    in_a = 8'h55; in_b = 8'h0A; in_cin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("stall_in_ready", in_ready, 0);
      check_eq("stall_out_valid", out_valid, 1);
      check_eq("stall_hold_sum", out_sum, 8'h03);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h55, 8'h0A, 1'b1, w);
    check_eq("stall_accept_wait", w, 0);
    drain(6);
    check_eq("stall_results", n_pop - n0, 3);

    // reset with results in flight
    send(8'hF0, 8'h20, 1'b0, w);
    send(8'h22, 8'h33, 1'b0, w);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    sat_q.delete();
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_in_ready", in_ready, 1);
`ifdef ADD_PIPE_OVF_CNT_EN
    check_eq("midrst_ovf_count", ovf_count, 0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_eq("midrst_no_stale", seen, 0);
    send(8'h7F, 8'h01, 1'b0, w);
    drain(5);

`ifdef ADD_PIPE_OVF_CNT_EN
    for (int i = 0; i < 5; i++) send(8'hF0, 8'h20, 1'b1, w);
    drain(5);
    check_eq("ovf_count_5", ovf_count, 5);
    for (int i = 0; i < 65530; i++) send(8'hFF, 8'hFF, 1'b1, w);
    drain(5);
    check_eq("ovf_count_full", ovf_count, 16'hFFFF);
    for (int i = 0; i < 5; i++) send(8'h80, 8'h80, 1'b0, w);
    drain(5);
    check_eq("ovf_count_sat", ovf_count, 16'hFFFF);
`endif

    check_eq("main_leftover", exp_q.size(), 0);
    check_eq("sat_leftover", sat_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
